hit_serializer: RTL and testbench
=================================

HIT_SERIALIZER -- requirements
Module: hit_serializer

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per position/color word.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits; carried through and not used in arithmetic.
REQ-003 SHALL have parameter AXIS, default 3, meaning axes per hit (x,y,z).
REQ-004 SHALL have parameter COLORS, default 3, meaning color channels.
REQ-005 SHALL have parameter SAMPS, default 4, meaning parallel samples per input group.
REQ-006 SHALL have parameter DEPTH, default 2, meaning group buffer entries; power of two, at least 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port hit_R18S, input, signed [SIGFIG-1:0] [AXIS][SAMPS]: hit locations from the sample-test stage.
REQ-010 SHALL have port color_R18U, input, unsigned [SIGFIG-1:0] [COLORS]: triangle color, shared by the group.
REQ-011 SHALL have port hit_valid_R18H, input, 1 bit [SAMPS]: per-sample hit flags.
REQ-012 SHALL have port halt_R18H, output, 1 bit: upstream stall; upstream holds its R18 outputs while high.
REQ-013 SHALL have port hit_R19S, output, signed [SIGFIG-1:0] [AXIS]: serialized hit location.
REQ-014 SHALL have port color_R19U, output, unsigned [SIGFIG-1:0] [COLORS]: color of the serialized hit.
REQ-015 SHALL have port hit_valid_R19H, output, 1 bit: the R19 outputs carry a valid hit.
REQ-016 SHALL have port ready_R19H, input, 1 bit: the downstream z-buffer accepts the current hit this cycle.

Function
REQ-017 SHALL define a group as accepted on a posedge when |hit_valid_R18H=1 and halt_R18H=0; the whole group (all SAMPS locations, color, and mask) is written to the buffer tail.
REQ-018 SHALL discard a group whose hit_valid_R18H is all zero, with no buffer write and no stall.
REQ-019 SHALL hold, per entry, a remaining-mask initialised to hit_valid_R18H at write.
REQ-020 SHALL drive halt_R18H = (count == DEPTH), derived only from registered state, with no dependence on ready_R19H.
REQ-021 SHALL drive hit_valid_R19H = (count != 0), again derived only from registered state.
REQ-022 SHALL drive hit_R19S from the head entry at sample index s, where s is the lowest set bit of the head remaining-mask; color_R19U SHALL come from the head entry.
REQ-023 SHALL treat a hit as transferred when hit_valid_R19H=1 and ready_R19H=1; on transfer, bit s of the head mask clears.
REQ-024 SHALL pop the head on a transfer that clears its last mask bit; the next entry presents on the following cycle with no bubble.
REQ-025 SHALL hold all R19 outputs stable while hit_valid_R19H=1 and ready_R19H=0.
REQ-026 SHALL have a latency of 1 cycle: a group accepted at edge N into an empty buffer shows hit_valid_R19H=1 after edge N.
REQ-027 SHALL sustain 1 hit per cycle; a group with k valid bits occupies the output for exactly k transfer cycles.
REQ-028 SHALL support push and pop on the same edge (count < DEPTH): count is unchanged, both pointers advance, and the pushed data is not corrupted.
REQ-029 SHALL wrap the read and write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-030 SHALL drive hit_R19S and color_R19U to zero when hit_valid_R19H=0.
REQ-031 SHALL preserve order: hits leave in group order, and within a group in ascending sample index.

Reset
REQ-032 SHALL, on an rst-high edge, clear count, pointers, and all masks, with halt_R18H=0 and hit_valid_R19H=0 from the next cycle; data outputs read 0.
REQ-033 SHALL, on rst asserted mid-operation, discard all buffered and partially sent groups and ignore that cycle's input group.
REQ-034 SHALL give rst priority over simultaneous accept and transfer.

Verification
REQ-035 SHALL cover: single group mask 4'b1010 with ready=1 -> hits for sample 1 then sample 3 on consecutive cycles, then hit_valid_R19H=0.
REQ-036 SHALL cover: mask 4'b0000 groups every cycle -> hit_valid_R19H and halt_R18H stay 0.
REQ-037 SHALL cover: ready=0 with two groups of mask 4'b1111 pushed -> halt_R18H=1 after the 2nd accept; a 3rd group is held and not lost; after ready=1, 12 hits emerge in order.
REQ-038 SHALL cover: ready toggling 1,0,1,0 on mask 4'b0111 -> each hit is held during ready=0, and exactly 3 transfers occur.
REQ-039 SHALL cover: back-to-back mask 4'b0001 groups with ready=1 -> 1 hit per cycle, count stays at 1, and pointers wrap without a bubble.
REQ-040 SHALL cover: rst pulsed with 2 groups buffered -> the next cycle shows hit_valid_R19H=0 and halt_R18H=0, with no stale hit after release.

Source files
------------

// File: rtl/hit_serializer_if.sv
// Hit bus between the sample-test stage (R18), the serializer, and the z-buffer (R19).
// The master modport is the environment side; the slave modport is the serializer.
interface hit_serializer_if #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
);
  logic signed [SIGFIG-1:0] hit_R18S [AXIS][SAMPS];
  logic        [SIGFIG-1:0] color_R18U [COLORS];
  logic        [SAMPS-1:0]  hit_valid_R18H;
  logic                     halt_R18H;
  logic signed [SIGFIG-1:0] hit_R19S [AXIS];
  logic        [SIGFIG-1:0] color_R19U [COLORS];
  logic                     hit_valid_R19H;
  logic                     ready_R19H;

  modport master (
    output hit_R18S, color_R18U, hit_valid_R18H, ready_R19H,
    input  halt_R18H, hit_R19S, color_R19U, hit_valid_R19H
  );

  modport slave (
    input  hit_R18S, color_R18U, hit_valid_R18H, ready_R19H,
    output halt_R18H, hit_R19S, color_R19U, hit_valid_R19H
  );
endinterface

// File: rtl/hit_serializer.sv
// Buffers groups of parallel sample hits and emits them one hit per cycle,
// lowest sample index first, with a DEPTH-entry group FIFO in front of the output.
module hit_serializer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4,
  parameter int DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  hit_serializer_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SAMPS > 1) ? $clog2(SAMPS) : 1;

  // RADIX only travels with the data format; it is checked here for sanity.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RADIX > SIGFIG)) begin : g_param_check
    $error("hit_serializer: DEPTH must be a power of two >= 2 and RADIX <= SIGFIG");
  end

  logic signed [SIGFIG-1:0] hit_mem_r   [DEPTH][AXIS][SAMPS];
  logic        [SIGFIG-1:0] color_mem_r [DEPTH][COLORS];
  logic        [SAMPS-1:0]  mask_r      [DEPTH];
  logic        [PW-1:0]     wr_ptr_r;
  logic        [PW-1:0]     rd_ptr_r;
  logic        [CW-1:0]     count_r;

  logic             full_s;
  logic             valid_s;
  logic             push_s;
  logic             transfer_s;
  logic             pop_s;
  logic [SAMPS-1:0] head_mask_s;
  logic [SAMPS-1:0] clr_mask_s;
  logic [SW-1:0]    sel_s;

  // Handshake decode and lowest-set-bit selection on the head entry.
  always_comb begin
    full_s      = (count_r == CW'(DEPTH));
    valid_s     = (count_r != {CW{1'b0}});
    head_mask_s = mask_r[rd_ptr_r];
    sel_s       = {SW{1'b0}};
    for (int i = SAMPS - 1; i >= 0; i--) begin
      sel_s = head_mask_s[i] ? SW'(i) : sel_s;
    end
    clr_mask_s = head_mask_s & ~({{(SAMPS-1){1'b0}}, 1'b1} << sel_s);
    push_s     = (|bus.hit_valid_R18H) && !full_s;
    transfer_s = valid_s && bus.ready_R19H;
    pop_s      = transfer_s && (clr_mask_s == {SAMPS{1'b0}});
  end

  // Outputs come only from registered state; data is forced to zero when idle.
  always_comb begin
    bus.halt_R18H      = full_s;
    bus.hit_valid_R19H = valid_s;
    for (int a = 0; a < AXIS; a++) begin
      bus.hit_R19S[a] = valid_s ? hit_mem_r[rd_ptr_r][a][sel_s] : {SIGFIG{1'b0}};
    end
    for (int c = 0; c < COLORS; c++) begin
      bus.color_R19U[c] = valid_s ? color_mem_r[rd_ptr_r][c] : {SIGFIG{1'b0}};
    end
  end

  // Pointers, occupancy and remaining-masks; reset wins over push and transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mask_r[i] <= {SAMPS{1'b0}};
      end
    end else begin
      if (transfer_s) begin
        mask_r[rd_ptr_r] <= clr_mask_s;
      end
      if (push_s) begin
        mask_r[wr_ptr_r] <= bus.hit_valid_R18H;
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Group payload storage; validity is tracked entirely by the masks above.
  always_ff @(posedge clk) begin
    if (push_s) begin
      for (int a = 0; a < AXIS; a++) begin
        for (int s = 0; s < SAMPS; s++) begin
          hit_mem_r[wr_ptr_r][a][s] <= bus.hit_R18S[a][s];
        end
      end
      for (int c = 0; c < COLORS; c++) begin
        color_mem_r[wr_ptr_r][c] <= bus.color_R18U[c];
      end
    end
  end
endmodule

// File: tb/tb_hit_serializer.sv
// Directed, table-driven bench for hit_serializer: one row per clock cycle,
// plus a hand-written hold-then-drain sequence with a bounded wait.
module tb_hit_serializer;
  localparam int SIGFIG = 24;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hit_serializer_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)) bus();

  hit_serializer #(
    .SIGFIG(SIGFIG), .RADIX(10), .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    int         grp;
    logic       rdy;
    logic       chk;
    logic       e_halt;
    logic       e_val;
    int         e_grp;
    int         e_smp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [SIGFIG-1:0] exp_hit(int g, int a, int s);
    return SIGFIG'(g * 256 + a * 16 + s);
  endfunction

  function automatic logic [SIGFIG-1:0] exp_col(int g, int c);
    return SIGFIG'(g * 4096 + c + 7);
  endfunction

  function automatic vec_t mk(logic r, logic [3:0] m, int g, logic rd, logic ck,
                              logic eh, logic ev, int eg, int es);
    vec_t v;
    v.rst = r; v.mask = m; v.grp = g; v.rdy = rd; v.chk = ck;
    v.e_halt = eh; v.e_val = ev; v.e_grp = eg; v.e_smp = es;
    return v;
  endfunction

  task automatic drive(logic r, logic [3:0] m, int g, logic rd);
    rst = r;
    bus.hit_valid_R18H = m;
    bus.ready_R19H = rd;
    for (int a = 0; a < AXIS; a++)
      for (int s = 0; s < SAMPS; s++)
        bus.hit_R18S[a][s] = exp_hit(g, a, s);
    for (int c = 0; c < COLORS; c++)
      bus.color_R18U[c] = exp_col(g, c);
  endtask

  task automatic check(string name, int row, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_out(int row, logic eh, logic ev, int eg, int es);
    logic [SIGFIG-1:0] e;
    check("halt", row, {63'b0, bus.halt_R18H}, {63'b0, eh});
    check("valid", row, {63'b0, bus.hit_valid_R19H}, {63'b0, ev});
    for (int a = 0; a < AXIS; a++) begin
      e = ev ? exp_hit(eg, a, es) : {SIGFIG{1'b0}};
      check("hit", row, {40'b0, bus.hit_R19S[a]}, {40'b0, e});
    end
    for (int c = 0; c < COLORS; c++) begin
      e = ev ? exp_col(eg, c) : {SIGFIG{1'b0}};
      check("color", row, {40'b0, bus.color_R19U[c]}, {40'b0, e});
    end
  endtask

  initial begin
    int k;
    int exp_s[2];
    exp_s[0] = 0;
    exp_s[1] = 3;
    // rst, mask, grp, rdy, chk, exp halt, exp valid, exp grp, exp sample
    vecs.push_back(mk(1'b1, 4'b0000,  0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0));
    // single group 1010 with ready high
    vecs.push_back(mk(1'b0, 4'b1010,  1, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  1, 1));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  1, 3));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    // empty masks are dropped every cycle
    vecs.push_back(mk(1'b0, 4'b0000,  2, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  2, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  2, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    // fill with ready low, third group held, then 12 hits drain
    vecs.push_back(mk(1'b0, 4'b1111,  3, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b1111,  4, 1'b0, 1'b1, 1'b0, 1'b1,  3, 0));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b0, 1'b1, 1'b1, 1'b1,  3, 0));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b0, 1'b1, 1'b1, 1'b1,  3, 0));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b1, 1'b1, 1'b1, 1'b1,  3, 0));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b1, 1'b1, 1'b1, 1'b1,  3, 1));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b1, 1'b1, 1'b1, 1'b1,  3, 2));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b1, 1'b1, 1'b1, 1'b1,  3, 3));
    vecs.push_back(mk(1'b0, 4'b1111,  5, 1'b1, 1'b1, 1'b0, 1'b1,  4, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b1, 1'b1,  4, 1));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b1, 1'b1,  4, 2));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b1, 1'b1,  4, 3));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  5, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  5, 1));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  5, 2));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  5, 3));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    // ready toggling on mask 0111
    vecs.push_back(mk(1'b0, 4'b0111,  6, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  6, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b0, 1'b1, 1'b0, 1'b1,  6, 1));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  6, 1));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b0, 1'b1, 1'b0, 1'b1,  6, 2));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1,  6, 2));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0));
    // back-to-back single-hit groups, pointers wrap with no bubble
    vecs.push_back(mk(1'b0, 4'b0001,  7, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0001,  8, 1'b1, 1'b1, 1'b0, 1'b1,  7, 0));
    vecs.push_back(mk(1'b0, 4'b0001,  9, 1'b1, 1'b1, 1'b0, 1'b1,  8, 0));
    vecs.push_back(mk(1'b0, 4'b0001, 10, 1'b1, 1'b1, 1'b0, 1'b1,  9, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b1, 10, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    // reset with a full buffer, then reset against a live accept+transfer
    vecs.push_back(mk(1'b0, 4'b1111, 11, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b1111, 12, 1'b0, 1'b1, 1'b0, 1'b1, 11, 0));
    vecs.push_back(mk(1'b1, 4'b1111, 13, 1'b1, 1'b1, 1'b1, 1'b1, 11, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0011, 14, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b1, 4'b1111, 15, 1'b1, 1'b1, 1'b0, 1'b1, 14, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));
    vecs.push_back(mk(1'b0, 4'b0000,  0, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mask, vecs[i].grp, vecs[i].rdy);
      @(negedge clk);
      if (vecs[i].chk)
        check_out(i, vecs[i].e_halt, vecs[i].e_val, vecs[i].e_grp, vecs[i].e_smp);
      @(posedge clk);
      #1;
    end

    // Hold a 1001 group with ready low, then drain within a bounded window.
    drive(1'b0, 4'b1001, 20, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 4'b0000, 0, 1'b0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check_out(100 + cyc, 1'b0, 1'b1, 20, 0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 4'b0000, 0, 1'b1);
    k = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (bus.hit_valid_R19H) begin
        if (k < 2) begin
          check_out(200 + cyc, 1'b0, 1'b1, 20, exp_s[k]);
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_hit row %0d: got sample %0h expected none", 200 + cyc,
                   bus.hit_R19S[0]);
        end
        k++;
      end
      @(posedge clk);
      #1;
    end
    check("xfer_count", 300, 64'(k), 64'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
